tmds_channel_encoder: RTL and testbench
=======================================

# tmds_channel_encoder

Single-channel DVI/HDMI TMDS 8b/10b encoder with running-disparity tracking. It runs in the pixel clock domain and maps one 8-bit colour component, or two control bits during blanking, to a 10-bit transition-minimised, DC-balanced symbol. Three instances (blue with {VSYNC,HSYNC}, green and red with ctrl = 0) sit between the video timing generator and the 10:1 serialiser inside the HDMI output stage.

## Interface
Parameters:
- None. Data width is fixed by the TMDS definition.

Ports:
- clk_pixel  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- de  in  1  data enable: 1 = active video (encode data), 0 = blanking (encode ctrl).
- data  in  8  pixel component, sampled when de = 1.
- ctrl  in  2  control bits {c1,c0}, sampled when de = 0.
- tmds_out  out  10  encoded symbol, bit 0 transmitted first by the serialiser.

## Operation
- Two-stage pipeline: S1 computes the minimised word q_m[8:0]. S2 applies DC balancing and produces tmds_out.
- S1, on a registered input:
  - n1d = popcount(data).
  - use_xnor = (n1d > 4) or (n1d == 4 and data[0] == 0).
  - q_m[0] = data[0].
  - q_m[i] = q_m[i-1] XNOR data[i] if use_xnor, else XOR, for i = 1..7.
  - q_m[8] = ~use_xnor.
  - de and ctrl are delayed alongside q_m.
- S2 when de is high:
  - n1 = popcount(q_m[7:0]), n0 = 8 − n1.
  - cnt is a 5-bit signed two's-complement disparity register. Its value stays within ±8 in legal operation, so no saturation logic is required.
  - Case A, cnt == 0 or n1 == n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1 − n0) : (n0 − n1).
  - Case B, (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (n0 − n1).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1 − n0) − 2·(~q_m[8]).
- S2 when de is low:
  - cnt ← 0.
  - ctrl 00 → 10'b1101010100.
  - ctrl 01 → 10'b0010101011.
  - ctrl 10 → 10'b0101010100.
  - ctrl 11 → 10'b1010101011.
- Popcounts and the cnt arithmetic are 5-bit signed. n1/n0 are zero-extended before subtraction.

## Timing
- Latency: 2 cycles. Inputs sampled at edge k appear on tmds_out after edge k+2, and one symbol is accepted every cycle. There is no handshake.
- Reset (rst high at an edge) forces:
  - tmds_out = 10'b1101010100;
  - cnt = 0;
  - pipelined de = 0 and ctrl = 00.
- Reset mid-frame takes effect at the next edge and discards any in-flight pixels.
- For the first 2 cycles after reset release, tmds_out is the ctrl-00 token.
- de transitions:
  - de 1→0: the first control token appears 2 cycles later, and cnt clears on that same cycle.
  - de 0→1: encoding starts from cnt = 0.
  - Pixel and control symbols never mix within one output cycle.

## Test plan
- Reset: hold rst for 3 cycles with arbitrary inputs → tmds_out = 0x354 (1101010100) and cnt = 0; after release, still 0x354 for 2 cycles.
- Control tokens: de = 0, ctrl stepping 00, 01, 10, 11 → tmds_out after 2 cycles is 0x354, 0x0AB, 0x154, 0x2AB in order.
- Disparity sequence: de = 1, data 0x00, 0x00 starting from cnt = 0:
  - first symbol 0x100 (0100000000), cnt = −8;
  - second symbol 0x3FF, cnt = +2.
- XNOR path: from cnt = 0, data 0xFF → q_m = 0x0FF with q_m[8] = 0; tmds_out = 0x200 (1000000000), cnt = −8.
- Blanking reset of disparity: after the 0x00 sequence, set de = 0 for 1 cycle, then data 0x00 again → tmds_out = 0x100 (Case A path, cnt restarted from 0).
- Random soak: 10 000 random de/data/ctrl cycles with a reference model plus a TMDS decoder:
  - output matches the model bit-exactly;
  - decoded data equals the input delayed by 2 cycles;
  - |cnt| ≤ 8 throughout;
  - one rst pulse is injected mid-run and the output matches the reset expectation above.

Source files
------------

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: input register, transition-minimising stage (S1),
// then DC-balancing stage (S2) with a running-disparity counter.
module tmds_channel_encoder (
  input  logic       clk_pixel,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds_out
);

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  // DC-balancing decision for one pixel symbol.
  typedef enum logic [1:0] {
    BAL_A,  // disparity neutral: polarity chosen by q_m[8]
    BAL_B,  // invert to pull disparity back towards zero
    BAL_C   // send as-is
  } bal_case_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic       de_in_d,   de_in_q;
  logic [7:0] data_in_d, data_in_q;
  logic [1:0] ctrl_in_d, ctrl_in_q;

  always_comb begin
    de_in_d   = de;
    data_in_d = data;
    ctrl_in_d = ctrl;
  end

  // ---------------------------------------------------------------------------
  // S1: transition minimisation
  // ---------------------------------------------------------------------------
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_d,     q_m_q;
  logic       de_s1_d,   de_s1_q;
  logic [1:0] ctrl_s1_d, ctrl_s1_q;

  // NOTE: every signal written in an always_comb gets a default before any
  // branch or loop; a path that leaves one unassigned infers a latch.
  always_comb begin
    n1d      = popcount8(data_in_q);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_in_q[0]);
    q_m_d    = '0;
    q_m_d[0] = data_in_q[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_in_q[i])
                          :  (q_m_d[i-1] ^ data_in_q[i]);
    end
    q_m_d[8]  = ~use_xnor;
    de_s1_d   = de_in_q;
    ctrl_s1_d = ctrl_in_q;
  end

  // ---------------------------------------------------------------------------
  // S2: DC balancing and control tokens
  // ---------------------------------------------------------------------------
  logic        [3:0] n1, n0;
  logic signed [4:0] n1_s, n0_s, diff;
  logic signed [4:0] two_q8, two_nq8;
  logic              cnt_pos, cnt_neg;
  bal_case_e         bal_case;
  logic signed [4:0] cnt_d, cnt_q;
  logic        [9:0] tmds_d, tmds_q;

  always_comb begin
    n1      = popcount8(q_m_q[7:0]);
    n0      = 4'd8 - n1;
    n1_s    = $signed({1'b0, n1});
    n0_s    = $signed({1'b0, n0});
    diff    = n1_s - n0_s;
    two_q8  = q_m_q[8] ? 5'sd2 : 5'sd0;
    two_nq8 = q_m_q[8] ? 5'sd0 : 5'sd2;
    cnt_neg = cnt_q[4];
    cnt_pos = !cnt_q[4] && (cnt_q != 5'sd0);

    if ((cnt_q == 5'sd0) || (n1 == n0)) begin
      bal_case = BAL_A;
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      bal_case = BAL_B;
    end else begin
      bal_case = BAL_C;
    end

    tmds_d = CTRL_TOK_00;
    cnt_d  = cnt_q;

    if (!de_s1_q) begin
      // Blanking restarts the disparity so the next active line begins balanced.
      cnt_d = 5'sd0;
      unique case (ctrl_s1_q)
        2'b00:   tmds_d = CTRL_TOK_00;
        2'b01:   tmds_d = CTRL_TOK_01;
        2'b10:   tmds_d = CTRL_TOK_10;
        default: tmds_d = CTRL_TOK_11;
      endcase
    end else begin
      unique case (bal_case)
        BAL_A: begin
          tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
          cnt_d  = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end
        BAL_B: begin
          tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
          cnt_d  = cnt_q + two_q8 - diff;
        end
        default: begin
          tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
          cnt_d  = cnt_q + diff - two_nq8;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      de_in_q   <= 1'b0;
      data_in_q <= '0;
      ctrl_in_q <= '0;
      q_m_q     <= '0;
      de_s1_q   <= 1'b0;
      ctrl_s1_q <= '0;
      cnt_q     <= 5'sd0;
      tmds_q    <= CTRL_TOK_00;
    end else begin
      de_in_q   <= de_in_d;
      data_in_q <= data_in_d;
      ctrl_in_q <= ctrl_in_d;
      q_m_q     <= q_m_d;
      de_s1_q   <= de_s1_d;
      ctrl_s1_q <= ctrl_s1_d;
      cnt_q     <= cnt_d;
      tmds_q    <= tmds_d;
    end
  end

  assign tmds_out = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: directed token/disparity cases
// plus a randomized soak against a queue-based reference model and a decoder.
module tb_tmds_channel_encoder;

  logic       clk_pixel = 1'b0;
  logic       rst       = 1'b1;
  logic       de        = 1'b0;
  logic [7:0] data      = '0;
  logic [1:0] ctrl      = '0;
  logic [9:0] tmds_out;

  tmds_channel_encoder dut (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .de        (de),
    .data      (data),
    .ctrl      (ctrl),
    .tmds_out  (tmds_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    bit       de;
    bit [7:0] data;
    bit [1:0] ctrl;
  } px_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: symbols wait in a two-deep queue, then are encoded from
  // the textual TMDS rules with plain integer arithmetic.
  logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  px_t        pipe[$];
  px_t        m_cur;
  int         m_cnt = 0;
  logic [9:0] m_out = 10'h354;

  task automatic model_edge(input bit r, input px_t in);
    px_t        p;
    int         n1d, n1, n0, q8;
    bit         xn;
    logic [7:0] qm;
    if (r) begin
      m_out = 10'h354;
      m_cnt = 0;
      pipe.delete();
      p = '{de: 1'b0, data: 8'h00, ctrl: 2'b00};
      pipe.push_back(p);
      pipe.push_back(p);
      m_cur = p;
      return;
    end
    p = pipe.pop_front();
    pipe.push_back(in);
    m_cur = p;
    if (!p.de) begin
      m_cnt = 0;
      m_out = tok[p.ctrl];
      return;
    end
    n1d   = $countones(p.data);
    xn    = (n1d > 4) || (n1d == 4 && p.data[0] == 1'b0);
    qm[0] = p.data[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ p.data[i]) : (qm[i-1] ^ p.data[i]);
    q8 = xn ? 0 : 1;
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (m_cnt == 0 || n1 == n0) begin
      m_out = {~q8[0], q8[0], (q8 == 1) ? qm : ~qm};
      m_cnt = m_cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
    end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      m_out = {1'b1, q8[0], ~qm};
      m_cnt = m_cnt + 2 * q8 + (n0 - n1);
    end else begin
      m_out = {1'b0, q8[0], qm};
      m_cnt = m_cnt + (n1 - n0) - 2 * (1 - q8);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input bit r, input bit d, input logic [7:0] dat, input logic [1:0] c);
    px_t p;
    int  dut_cnt;
    rst  = r;
    de   = d;
    data = dat;
    ctrl = c;
    p    = '{de: d, data: dat, ctrl: c};
    @(posedge clk_pixel);
    model_edge(r, p);
    #1;
    dut_cnt = int'(dut.cnt_q);
    check("tmds", int'(tmds_out), int'(m_out));
    check("cnt", dut_cnt, m_cnt);
    check("cnt_bound", int'(dut_cnt <= 8 && dut_cnt >= -8), 1);
    if (!r && m_cur.de) check("decode", int'(decode(tmds_out)), int'(m_cur.data));
  endtask

  initial begin
    // Reset held 3 cycles with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
      check("reset_tok", int'(tmds_out), 'h354);
      check("reset_cnt", int'(dut.cnt_q), 0);
    end
    // Two cycles of ctrl-00 after release even with active input.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 2'b11);
      check("post_reset_tok", int'(tmds_out), 'h354);
    end

    // Control tokens stepping 00,01,10,11.
    step(1'b0, 1'b0, 8'h5A, 2'b00);
    step(1'b0, 1'b0, 8'h5A, 2'b01);
    step(1'b0, 1'b0, 8'h5A, 2'b10);
    check("ctrl00", int'(tmds_out), 'h354);
    step(1'b0, 1'b0, 8'h5A, 2'b11);
    check("ctrl01", int'(tmds_out), 'h0AB);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("ctrl10", int'(tmds_out), 'h154);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("ctrl11", int'(tmds_out), 'h2AB);

    // Disparity sequence, blanking restart and XNOR path.
    step(1'b0, 1'b1, 8'h00, 2'b00);
    step(1'b0, 1'b1, 8'h00, 2'b00);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("zero_first", int'(tmds_out), 'h100);
    check("zero_first_cnt", int'(dut.cnt_q), -8);
    step(1'b0, 1'b1, 8'h00, 2'b00);
    check("zero_second", int'(tmds_out), 'h3FF);
    check("zero_second_cnt", int'(dut.cnt_q), 2);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("blank_tok", int'(tmds_out), 'h354);
    check("blank_cnt", int'(dut.cnt_q), 0);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("restart_zero", int'(tmds_out), 'h100);
    step(1'b0, 1'b1, 8'hFF, 2'b00);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    check("xnor_ff", int'(tmds_out), 'h200);
    check("xnor_ff_cnt", int'(dut.cnt_q), -8);

    // Random soak with one mid-run reset pulse.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        step(1'b1, 1'b1, 8'($urandom), 2'($urandom));
        check("soak_reset_tok", int'(tmds_out), 'h354);
      end else begin
        step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
